// File: rtl/voltage_convert_multi.sv
// Multi-channel averaging ADC-to-voltage converter with interpolated calibration.
// Four-stage pipeline: accumulate, scale to volts x100, pick calibration, apply and clamp.
module voltage_convert_multi #(
    parameter int unsigned ADC_W      = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned VREF       = 500,
    parameter int unsigned SCALE_BASE = 100,
    parameter int unsigned SCALE_MIN  = 132,
    parameter int unsigned SCALE_MAX  = 133,
    parameter int unsigned V_MIN      = 100,
    parameter int unsigned V_MAX      = 500,
    parameter int unsigned OUT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [CH_W-1:0]  adc_ch,
    input  logic             adc_valid,
    input  logic             acc_clear,
    output logic [OUT_W-1:0] voltage,
    output logic [CH_W-1:0]  volt_ch,
    output logic             volt_valid,
    output logic             volt_sat,
    output logic             ch_err
);

    localparam int unsigned ACC_W      = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned RAW_W      = $clog2(VREF + 1);
    localparam int unsigned SCALE_TOP  = (SCALE_MAX > SCALE_MIN) ? SCALE_MAX : SCALE_MIN;
    localparam int unsigned SCALE_W    = $clog2(SCALE_TOP + 1);
    localparam int unsigned FULL_SCALE = 32'((64'd1 << ADC_W) - 64'd1);
    localparam int unsigned OUT_MAX    = 32'((64'd1 << OUT_W) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((64'd1 << AVG_LOG2) - 64'd1);

    // Stage 0 state: per-channel running sums and sample counts
    logic [ACC_W-1:0] acc [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];

    logic             s1_valid, s2_valid, s3_valid;
    logic [ACC_W-1:0] s1_sum;
    logic [CH_W-1:0]  s1_ch, s2_ch, s3_ch;
    logic [RAW_W-1:0] s2_raw, s3_raw;
    logic [SCALE_W-1:0] s3_scale;

    logic             ch_ok_c;
    logic [CH_W-1:0]  ch_idx_c;
    logic [ACC_W-1:0] sum_c;
    logic [31:0]      avg_c;
    logic [31:0]      raw_c;
    logic [31:0]      raw2_c;
    logic [31:0]      scale_c;
    logic [31:0]      prod_c;
    logic             sat_c;

    // Channel decode; out-of-range tags are steered to index 0 but never written
    always_comb begin
        ch_ok_c  = 1'b0;
        ch_idx_c = '0;
        sum_c    = '0;
        ch_ok_c  = (32'(adc_ch) < NUM_CH);
        ch_idx_c = ch_ok_c ? adc_ch : '0;
        sum_c    = acc[ch_idx_c] + ACC_W'(adc_data);
    end

    // Stage 0: accumulate; a block completes when the last sample of 2^AVG_LOG2 arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ch    <= '0;
            ch_err   <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (adc_valid && !ch_ok_c) begin
                ch_err <= 1'b1;
            end
            if (acc_clear) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (adc_valid && ch_ok_c) begin
                if (cnt[ch_idx_c] == CNT_LAST) begin
                    acc[ch_idx_c] <= '0;
                    cnt[ch_idx_c] <= '0;
                    s1_sum        <= sum_c;
                    s1_ch         <= adc_ch;
                    s1_valid      <= 1'b1;
                end else begin
                    acc[ch_idx_c] <= sum_c;
                    cnt[ch_idx_c] <= cnt[ch_idx_c] + CNT_W'(1);
                end
            end
        end
    end

    // Stage 1 math: average then map to volts x100 against full scale
    always_comb begin
        avg_c = '0;
        raw_c = '0;
        avg_c = 32'(s1_sum >> AVG_LOG2);
        raw_c = (avg_c * VREF) / FULL_SCALE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_raw   <= '0;
            s2_ch    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_raw   <= RAW_W'(raw_c);
            s2_ch    <= s1_ch;
        end
    end

    // Stage 2 math: clamp outside [V_MIN, V_MAX], linear interpolation inside
    always_comb begin
        raw2_c  = 32'(s2_raw);
        scale_c = SCALE_MIN;
        if (raw2_c <= V_MIN) begin
            scale_c = SCALE_MIN;
        end else if (raw2_c >= V_MAX) begin
            scale_c = SCALE_MAX;
        end else begin
            scale_c = SCALE_MIN + ((raw2_c - V_MIN) * (SCALE_MAX - SCALE_MIN)) / (V_MAX - V_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_raw   <= '0;
            s3_scale <= '0;
            s3_ch    <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_raw   <= s2_raw;
            s3_scale <= SCALE_W'(scale_c);
            s3_ch    <= s2_ch;
        end
    end

    // Stage 3 math: apply calibration; a zero raw value yields zero naturally
    always_comb begin
        prod_c = '0;
        sat_c  = 1'b0;
        prod_c = (32'(s3_raw) * 32'(s3_scale)) / SCALE_BASE;
        sat_c  = (prod_c > OUT_MAX);
    end

    // Output register: result fields hold between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            voltage    <= '0;
            volt_ch    <= '0;
            volt_valid <= 1'b0;
            volt_sat   <= 1'b0;
        end else begin
            volt_valid <= s3_valid;
            if (s3_valid) begin
                voltage  <= sat_c ? OUT_W'(OUT_MAX) : OUT_W'(prod_c);
                volt_ch  <= s3_ch;
                volt_sat <= sat_c;
            end
        end
    end

endmodule
